// File: rtl/updown_counter_mod.sv
// Parametrised up/down modulus counter with load, enable, tc and wrap flag.
// Define COUNTER_SATURATE_EN to saturate at the limits with a sticky flag on wrap.
module updown_counter_mod #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             wrap
);

    if (WIDTH < 2 || WIDTH > 16) begin : g_bad_width
        $error("updown_counter_mod: WIDTH must be 2..16");
    end
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_mod
        $error("updown_counter_mod: MODULUS must be 2..2**WIDTH");
    end

    localparam logic [WIDTH-1:0] MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic [WIDTH-1:0] w_q_next;
    logic             w_wrap_next;
    logic [WIDTH-1:0] w_load_q;
    logic             w_at_max;
    logic             w_at_zero;
    logic             w_tc;

    assign w_at_max  = (r_q == MAX);
    assign w_at_zero = (r_q == '0);
    assign w_tc      = en & (up_dn ? w_at_max : w_at_zero);
    assign w_load_q  = (load_val > MAX) ? MAX : load_val;

    // All arithmetic stays WIDTH bits; the limit tests handle full-range moduli.
    always_comb begin
        w_q_next    = r_q;
        w_wrap_next = 1'b0;
        if (load) begin
            w_q_next    = w_load_q;
            w_wrap_next = 1'b0;
        end else if (en) begin
`ifdef COUNTER_SATURATE_EN
            if (up_dn) begin
                w_q_next = w_at_max ? r_q : r_q + ONE;
            end else begin
                w_q_next = w_at_zero ? r_q : r_q - ONE;
            end
            w_wrap_next = r_wrap | w_tc;
`else
            if (up_dn) begin
                w_q_next = w_at_max ? '0 : r_q + ONE;
            end else begin
                w_q_next = w_at_zero ? MAX : r_q - ONE;
            end
            w_wrap_next = w_tc;
`endif
        end else begin
`ifdef COUNTER_SATURATE_EN
            w_wrap_next = r_wrap;
`else
            w_wrap_next = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else begin
            r_q    <= w_q_next;
            r_wrap <= w_wrap_next;
        end
    end

    assign Q    = r_q;
    assign tc   = w_tc;
    assign wrap = r_wrap;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Scoreboard bench for updown_counter_mod: a 4-bit/mod-16 and a 3-bit/mod-6
// instance share stimulus; each expected entry names the instance it checks.
module tb_updown_counter_mod;

    typedef struct packed {
        logic       sel;
        logic [3:0] q;
        logic       tc;
        logic       wr;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       up = 1'b1;
    logic       ld = 1'b0;
    logic [3:0] lv = '0;

    logic [3:0] q4;
    logic       tc4, wr4;
    logic [2:0] q3;
    logic       tc3, wr3;

    exp_t  exp_q[$];
    string nm_q[$];
    event  smp;
    int    checks = 0;
    int    failures = 0;

    logic [3:0] dq [7] = '{4'd5, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd5};
    logic       dtc[7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       dwr[7] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    updown_counter_mod u_d4 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up), .load(ld),
        .load_val(lv), .Q(q4), .tc(tc4), .wrap(wr4)
    );

    updown_counter_mod #(.WIDTH(3), .MODULUS(6)) u_d3 (
        .clk(clk), .reset(reset), .en(en), .up_dn(up), .load(ld),
        .load_val(lv[2:0]), .Q(q3), .tc(tc3), .wrap(wr3)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ->smp;
    end

    exp_t       m_e;
    string      m_nm;
    logic [5:0] m_act;

    always @(smp) begin
        if (exp_q.size() > 0) begin
            m_e  = exp_q.pop_front();
            m_nm = nm_q.pop_front();
            m_act = m_e.sel ? {1'b0, q3, tc3, wr3} : {q4, tc4, wr4};
            checks++;
            if (m_act !== {m_e.q, m_e.tc, m_e.wr}) begin
                failures++;
                $display("FAIL %s: got Q=%0d tc=%b wrap=%b, want Q=%0d tc=%b wrap=%b",
                         m_nm, m_act[5:2], m_act[1], m_act[0],
                         m_e.q, m_e.tc, m_e.wr);
            end
        end
    end

    task automatic push(input logic s, input logic [3:0] eq,
                        input logic et, input logic ew, input string nm);
        exp_t e;
        e.sel = s;
        e.q   = eq;
        e.tc  = et;
        e.wr  = ew;
        exp_q.push_back(e);
        nm_q.push_back(nm);
    endtask

    task automatic vec(input logic s, input logic e, input logic u,
                       input logic l, input logic [3:0] v,
                       input logic [3:0] eq, input logic et,
                       input logic ew, input string nm);
        @(negedge clk);
        en = e;
        up = u;
        ld = l;
        lv = v;
        push(s, eq, et, ew, nm);
    endtask

    task automatic rst_pulse();
        @(negedge clk);
        reset = 1'b1;
        en = 1'b0;
        ld = 1'b0;
        up = 1'b1;
        lv = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic midrst(input logic s, input string nm);
        @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        push(s, 4'd0, 1'b0, 1'b0, nm);
        ->smp;
        @(negedge clk);
        reset = 1'b0;
        en = 1'b0;
    endtask

    initial begin
        #3;
        push(1'b0, 4'd0, 1'b0, 1'b0, "reset_d4");
        ->smp;
        #1;
        push(1'b1, 4'd0, 1'b0, 1'b0, "reset_d3");
        ->smp;
        @(negedge clk);
        reset = 1'b0;

`ifndef COUNTER_SATURATE_EN
        for (int i = 1; i <= 17; i++)
            vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 16),
                i == 15, i == 16, $sformatf("up16_%0d", i));

        rst_pulse();
        for (int i = 0; i < 7; i++)
            vec(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, dq[i], dtc[i], dwr[i],
                $sformatf("down6_%0d", i));

        vec(1'b1, 1'b0, 1'b1, 1'b1, 4'd3, 4'd3, 1'b0, 1'b0, "load3");
        vec(1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 4'd5, 1'b0, 1'b0, "load7_clamp");
        vec(1'b1, 1'b1, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, "load_over_en");
        vec(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, "up_3");
        vec(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd4, 1'b0, 1'b0, "up_4");
        vec(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd3, 1'b0, 1'b0, "dir_3");
        vec(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, "dir_2");
        vec(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "dir_1");
        vec(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "hold_a");
        vec(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "hold_b");
`else
        rst_pulse();
        for (int i = 1; i <= 8; i++)
            vec(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, (i < 5) ? 4'(i) : 4'd5,
                i >= 5, i >= 6, $sformatf("sat_%0d", i));
        vec(1'b1, 1'b0, 1'b1, 1'b1, 4'd2, 4'd2, 1'b0, 1'b0, "sat_load");
        vec(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, "sat_hold");
`endif

        rst_pulse();
        for (int i = 1; i <= 9; i++)
            vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i), 1'b0, 1'b0,
                $sformatf("to9_%0d", i));
        midrst(1'b0, "async_rst_q9");
        vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd1, 1'b0, 1'b0, "resume_1");
        vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'd2, 1'b0, 1'b0, "resume_2");

`ifndef COUNTER_SATURATE_EN
        rst_pulse();
        for (int i = 1; i <= 16; i++)
            vec(1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 4'(i % 16),
                i == 15, i == 16, $sformatf("towrap_%0d", i));
        midrst(1'b0, "async_rst_wrap");
`endif

        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
